// File: rtl/mux_n_ne_1_regjistruar_if.sv
// mux_n_ne_1_regjistruar_if: producer/consumer bundle of the registered N-to-1 channel mux.
interface mux_n_ne_1_regjistruar_if #(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);
    logic [CHANNELS*WIDTH-1:0] Hyrja;
    logic [CHANNELS-1:0]       HyrjaValid;
    logic [CHANNELS-1:0]       HyrjaReady;
    logic [SEL_W-1:0]          S;
    logic                      Mode;
    logic [WIDTH-1:0]          M;
    logic                      MValid;
    logic                      MReady;
    logic [SEL_W-1:0]          Zgjedhur;
    modport master (
        output Hyrja, HyrjaValid, S, Mode, MReady,
        input  HyrjaReady, M, MValid, Zgjedhur
    );
    modport slave (
        input  Hyrja, HyrjaValid, S, Mode, MReady,
        output HyrjaReady, M, MValid, Zgjedhur
    );
endinterface

// File: rtl/mux_n_ne_1_regjistruar.sv
// mux_n_ne_1_regjistruar: registered N-to-1 channel mux, fixed select or round-robin grant,
// single-entry output register behind a valid/ready handshake.
module mux_n_ne_1_regjistruar #(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input logic                     Clock,
    input logic                     Reset,
    mux_n_ne_1_regjistruar_if.slave bus
);
    logic [WIDTH-1:0] m_q, m_d;
    logic             mvalid_q, mvalid_d;
    logic [SEL_W-1:0] zgj_q, zgj_d, p_q, p_d, gnt;
    logic             gnt_ok, space, load;
    // Descending scan so the channel nearest the pointer wins the last assignment.
    always_comb begin
        gnt_ok = 1'b0;
        gnt    = bus.S;
        if (!bus.Mode)
            gnt_ok = int'(bus.S) < CHANNELS;
        else
            for (int i = CHANNELS - 1; i >= 0; i--)
                if (bus.HyrjaValid[(int'(p_q) + i) % CHANNELS]) begin
                    gnt_ok = 1'b1;
                    gnt    = SEL_W'((int'(p_q) + i) % CHANNELS);
                end
    end
    assign space = !mvalid_q || bus.MReady;
    assign load  = space && gnt_ok && bus.HyrjaValid[gnt];
    assign bus.HyrjaReady = (space && gnt_ok && !Reset) ? CHANNELS'(1) << gnt : '0;
    always_comb begin
        m_d      = load ? bus.Hyrja[int'(gnt)*WIDTH +: WIDTH] : m_q;
        zgj_d    = load ? gnt : zgj_q;
        mvalid_d = load || (mvalid_q && !bus.MReady);
        p_d      = (load && bus.Mode) ? (int'(gnt) == CHANNELS - 1 ? '0 : gnt + 1'b1) : p_q;
    end
    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            m_q      <= '0;
            mvalid_q <= 1'b0;
            zgj_q    <= '0;
            p_q      <= '0;
        end else begin
            m_q      <= m_d;
            mvalid_q <= mvalid_d;
            zgj_q    <= zgj_d;
            p_q      <= p_d;
        end
    assign bus.M        = m_q;
    assign bus.MValid   = mvalid_q;
    assign bus.Zgjedhur = zgj_q;
endmodule

// File: doc/mux_n_ne_1_regjistruar.md
# mux_n_ne_1_regjistruar

Parametrised, registered N-to-1 channel multiplexer for the 24-bit datapath. It selects one of CHANNELS input words, either by explicit select (fixed mode) or by round-robin arbitration among valid channels. The result is held in a single output register behind a valid/ready handshake. It sits between operand or result producers (register file ports, ALU, memory read) and a single consumer, and replaces ad-hoc chains of 1-bit 2:1 muxes.

## Interface
- WIDTH, 24, data word width in bits (≥1)
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, $clog2(CHANNELS), select/index width (derived; do not override)

- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Hyrja  in  CHANNELS*WIDTH  input words; channel k occupies bits [k*WIDTH +: WIDTH]
- HyrjaValid  in  CHANNELS  per-channel valid
- HyrjaReady  out  CHANNELS  per-channel ready (one-hot or zero; combinational)
- S  in  SEL_W  channel select, used only when Mode=0
- Mode  in  1  0 = fixed select by S; 1 = round-robin
- M  out  WIDTH  registered output word
- MValid  out  1  M holds an unconsumed word
- MReady  in  1  consumer accepts M this cycle
- Zgjedhur  out  SEL_W  index of the channel that produced M

## Operation
- Output register is a single entry with two states: EMPTY (MValid=0) and FULL (MValid=1).
- Load enable is L = (!MValid | MReady) & granted-channel valid. Consumption and a new load may happen in the same cycle.
- Fixed mode (Mode=0):
  - Grant channel S.
  - If S ≥ CHANNELS (non-power-of-2 CHANNELS), there is no grant, all HyrjaReady=0, and no load.
- Round-robin mode (Mode=1):
  - Round-robin pointer P has SEL_W bits.
  - Grant the first k with HyrjaValid[k]=1, searching cyclically from P: P, P+1, …, CHANNELS-1, 0, …, P-1.
  - On a load, P ← (granted+1) mod CHANNELS.
  - With no valid channel there is no grant and P is held.
- Readiness: HyrjaReady[k] = 1 only for the granted channel, and only when (!MValid | MReady). A transfer on channel k occurs exactly when HyrjaValid[k] & HyrjaReady[k].
- On load: M ← granted word, Zgjedhur ← granted index, MValid ← 1.
- On MReady & MValid with no load: MValid ← 0. M and Zgjedhur hold their last values.
- While FULL and !MReady: M, Zgjedhur and MValid are stable. Input changes have no effect on them.
- P is held in fixed mode. Switching Mode takes effect on the grant in the same cycle; P is never reset by a mode change.
- No width arithmetic other than the modulo increment of P, which wraps from CHANNELS-1 to 0.

## Timing
- Reset values, applied asynchronously and immediately: M=0, MValid=0, Zgjedhur=0, P=0. HyrjaReady=0 while Reset is high.
- Reset asserted while FULL discards the held word. No transfer is acknowledged in that cycle.
- Latency: a word accepted at edge n appears on M with MValid=1 after edge n.
- Throughput: one word per cycle when MReady is held high.
- HyrjaReady depends combinationally on MReady, MValid, Mode, S, HyrjaValid and P. There is no combinational path from Hyrja to any output.
- Producers must hold Hyrja[k] and HyrjaValid[k] until the transfer occurs. The block does not require this, but otherwise the granted word is whatever is present at the load edge.

## Test plan
- Reset, fixed load, hold:
  - Stimulus: reset, then Mode=0, S=2, channel 2 = 24'hABCDEF valid, MReady=0.
  - Response: after one edge M=24'hABCDEF, MValid=1, Zgjedhur=2.
  - Holding for 3 cycles keeps M stable and HyrjaReady=0.
- Full-rate streaming:
  - Stimulus: Mode=0, S=1, channel 1 valid with a new word each cycle (1,2,3,4), MReady=1.
  - Response: M shows 1,2,3,4 on consecutive cycles; MValid stays 1; no gaps.
- Round-robin fairness:
  - Stimulus: Mode=1, all 4 channels valid, MReady=1.
  - Response: Zgjedhur sequence 0,1,2,3,0. With only channels 1 and 3 valid: 1,3,1,3.
- Round-robin skip and wrap:
  - Setup: P=3 (after granting 2); only channel 0 valid.
  - Response: channel 0 is granted and P becomes 1.
- Out-of-range select and back-pressure:
  - Stimulus: CHANNELS=3 and S=3; separately, FULL with MReady=0.
  - Response: HyrjaReady=0, MValid unchanged.
- Async reset mid-operation:
  - Stimulus: assert Reset between edges while FULL.
  - Response: MValid, M, Zgjedhur go to 0 without waiting for a clock edge. P=0 after release.
  - Round-robin then restarts granting from channel 0.
